// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and Gray-code helpers for the async FIFO
package fifo_pkg;

  localparam int FIFO_DATA_W      = 32;
  localparam int FIFO_ADDR_W      = 5;
  localparam int FIFO_SYNC_STAGES = 2;
  localparam int FIFO_MAX_W       = 32;

  // Operands are zero-extended to FIFO_MAX_W; leading zeros leave both codes unchanged,
  // so callers of any width up to FIFO_MAX_W cast in and truncate the result back.
  function automatic logic [FIFO_MAX_W-1:0] bin2gray(input logic [FIFO_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FIFO_MAX_W-1:0] gray2bin(input logic [FIFO_MAX_W-1:0] g);
    logic [FIFO_MAX_W-1:0] b;
    b[FIFO_MAX_W-1] = g[FIFO_MAX_W-1];
    for (int i = FIFO_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_if.sv
// rtl/async_fifo_rd_ctrl_if.sv - read-side consumer and RAM port bundle
interface async_fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
);
  logic              read_enable;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic [ADDR_W-1:0] mem_raddr;
  logic              mem_ren;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output read_enable, mem_rdata,
    input  read_data, read_valid, mem_raddr, mem_ren
  );

  modport slave (
    input  read_enable, mem_rdata,
    output read_data, read_valid, mem_raddr, mem_ren
  );
endinterface

// File: rtl/fifo_ptr_sync.sv
// rtl/fifo_ptr_sync.sv - multi-flop synchroniser for a Gray-coded FIFO pointer
module fifo_ptr_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_ADDR_W + 1,
  parameter int STAGES = FIFO_SYNC_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sw_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else if (i_sw_rst) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// rtl/async_fifo_rd_ctrl.sv - read-domain pointer, flags, level and RAM addressing
module async_fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W           = FIFO_DATA_W,
  parameter int ADDR_W           = FIFO_ADDR_W,
  parameter int SYNC_STAGES      = FIFO_SYNC_STAGES,
  parameter bit FWFT             = 1'b0,
  parameter bit STICKY_UNDERFLOW = 1'b0
) (
  input  logic              rclk,
  input  logic              hw_rst_n,
  input  logic              sw_rst,
  input  logic [ADDR_W-1:0] aempty_value,
  input  logic [ADDR_W:0]   wptr_gray,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              rdempty,
  output logic              rd_almost_empty,
  output logic              underflow,
  output logic [ADDR_W:0]   fifo_read_count,
  output logic [ADDR_W:0]   rd_level,
  async_fifo_rd_ctrl_if.slave rd_if
);

  logic [ADDR_W:0]   w_wq_gray;
  logic [ADDR_W:0]   w_wq_bin;
  logic [ADDR_W:0]   w_rptr_bin_next;
  logic [ADDR_W:0]   w_rptr_gray_next;
  logic [ADDR_W:0]   w_rd_level_next;
  logic              w_accept;
  logic              w_underflow_evt;
  logic              w_underflow_next;
  logic [DATA_W-1:0] w_read_data;

  logic [ADDR_W:0]   r_rptr_bin;
  logic [ADDR_W:0]   r_rptr_gray;
  logic [ADDR_W:0]   r_rd_level;
  logic              r_rdempty;
  logic              r_almost_empty;
  logic              r_underflow;

  fifo_ptr_sync #(
    .WIDTH  (ADDR_W + 1),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .i_clk    (rclk),
    .i_rst_n  (hw_rst_n),
    .i_sw_rst (sw_rst),
    .i_d      (wptr_gray),
    .o_q      (w_wq_gray)
  );

  always_comb begin
    w_accept         = rd_if.read_enable && !r_rdempty;
    w_underflow_evt  = rd_if.read_enable && r_rdempty;
    w_rptr_bin_next  = r_rptr_bin + {{ADDR_W{1'b0}}, w_accept};
    w_rptr_gray_next = (ADDR_W+1)'(bin2gray(FIFO_MAX_W'(w_rptr_bin_next)));
    w_wq_bin         = (ADDR_W+1)'(gray2bin(FIFO_MAX_W'(w_wq_gray)));
    w_rd_level_next  = w_wq_bin - w_rptr_bin_next;
    w_underflow_next = w_underflow_evt || (STICKY_UNDERFLOW && r_underflow);
  end

  // Flags come from next-state values so the cycle after the last accept already shows empty.
  always_ff @(posedge rclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      r_rptr_bin     <= '0;
      r_rptr_gray    <= '0;
      r_rd_level     <= '0;
      r_rdempty      <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else if (sw_rst) begin
      r_rptr_bin     <= '0;
      r_rptr_gray    <= '0;
      r_rd_level     <= '0;
      r_rdempty      <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      r_rptr_bin     <= w_rptr_bin_next;
      r_rptr_gray    <= w_rptr_gray_next;
      r_rd_level     <= w_rd_level_next;
      r_rdempty      <= (w_rptr_gray_next == w_wq_gray);
      r_almost_empty <= (w_rd_level_next <= {1'b0, aempty_value});
      r_underflow    <= w_underflow_next;
    end
  end

  // FWFT keeps the RAM prefetching the entry at the post-accept pointer, so the head is
  // always sitting in the registered RAM output one cycle later.
  if (FWFT) begin : g_fwft
    assign rd_if.mem_raddr  = w_rptr_bin_next[ADDR_W-1:0];
    assign rd_if.mem_ren    = 1'b1;
    assign rd_if.read_valid = !r_rdempty;
  end else begin : g_std
    logic r_read_valid;

    always_ff @(posedge rclk or negedge hw_rst_n) begin
      if (!hw_rst_n) begin
        r_read_valid <= 1'b0;
      end else if (sw_rst) begin
        r_read_valid <= 1'b0;
      end else begin
        r_read_valid <= w_accept;
      end
    end

    assign rd_if.mem_raddr  = r_rptr_bin[ADDR_W-1:0];
    assign rd_if.mem_ren    = w_accept;
    assign rd_if.read_valid = r_read_valid;
  end

  assign w_read_data     = rd_if.mem_rdata;
  assign rd_if.read_data = w_read_data;

  assign rptr_gray       = r_rptr_gray;
  assign rdempty         = r_rdempty;
  assign rd_almost_empty = r_almost_empty;
  assign underflow       = r_underflow;
  assign fifo_read_count = r_rptr_bin;
  assign rd_level        = r_rd_level;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// tb/tb_async_fifo_rd_ctrl.sv - directed bench for standard, sticky and FWFT read controllers
module tb_async_fifo_rd_ctrl;

  logic       rclk = 1'b0;
  logic       hw_rst_n;
  logic       sw_rst;
  logic [4:0] aempty_value;
  logic [5:0] wptr_gray;
  logic [5:0] wbin;

  logic [31:0] mem [32];
  logic [31:0] rdata_std, rdata_stk, rdata_fw;

  logic [5:0] rptr_gray_std, rptr_gray_stk, rptr_gray_fw;
  logic       rdempty_std, rdempty_stk, rdempty_fw;
  logic       ae_std, ae_stk, ae_fw;
  logic       uf_std, uf_stk, uf_fw;
  logic [5:0] cnt_std, cnt_stk, cnt_fw;
  logic [5:0] lvl_std, lvl_stk, lvl_fw;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 rclk = ~rclk;

  async_fifo_rd_ctrl_if #(.DATA_W(32), .ADDR_W(5)) if_std ();
  async_fifo_rd_ctrl_if #(.DATA_W(32), .ADDR_W(5)) if_stk ();
  async_fifo_rd_ctrl_if #(.DATA_W(32), .ADDR_W(5)) if_fw ();

  assign if_std.mem_rdata = rdata_std;
  assign if_stk.mem_rdata = rdata_stk;
  assign if_fw.mem_rdata  = rdata_fw;

  always @(posedge rclk) begin
    if (if_std.mem_ren) rdata_std <= mem[if_std.mem_raddr];
    if (if_stk.mem_ren) rdata_stk <= mem[if_stk.mem_raddr];
    if (if_fw.mem_ren)  rdata_fw  <= mem[if_fw.mem_raddr];
  end

  async_fifo_rd_ctrl #(.DATA_W(32), .ADDR_W(5), .SYNC_STAGES(2), .FWFT(1'b0), .STICKY_UNDERFLOW(1'b0)) u_std (
    .rclk(rclk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .aempty_value(aempty_value),
    .wptr_gray(wptr_gray), .rptr_gray(rptr_gray_std), .rdempty(rdempty_std),
    .rd_almost_empty(ae_std), .underflow(uf_std), .fifo_read_count(cnt_std),
    .rd_level(lvl_std), .rd_if(if_std));

  async_fifo_rd_ctrl #(.DATA_W(32), .ADDR_W(5), .SYNC_STAGES(2), .FWFT(1'b0), .STICKY_UNDERFLOW(1'b1)) u_stk (
    .rclk(rclk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .aempty_value(aempty_value),
    .wptr_gray(wptr_gray), .rptr_gray(rptr_gray_stk), .rdempty(rdempty_stk),
    .rd_almost_empty(ae_stk), .underflow(uf_stk), .fifo_read_count(cnt_stk),
    .rd_level(lvl_stk), .rd_if(if_stk));

  async_fifo_rd_ctrl #(.DATA_W(32), .ADDR_W(5), .SYNC_STAGES(2), .FWFT(1'b1), .STICKY_UNDERFLOW(1'b0)) u_fw (
    .rclk(rclk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .aempty_value(aempty_value),
    .wptr_gray(wptr_gray), .rptr_gray(rptr_gray_fw), .rdempty(rdempty_fw),
    .rd_almost_empty(ae_fw), .underflow(uf_fw), .fifo_read_count(cnt_fw),
    .rd_level(lvl_fw), .rd_if(if_fw));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic set_wptr(input logic [5:0] b);
    wbin      = b;
    wptr_gray = b ^ (b >> 1);
  endtask

  task automatic do_sw_rst();
    if_std.read_enable = 1'b0;
    if_stk.read_enable = 1'b0;
    if_fw.read_enable  = 1'b0;
    sw_rst = 1'b1;
    set_wptr(6'd0);
    tick(1);
    sw_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_rd;
    int wcnt;
    int cyc;
    logic saw_wrap;
    logic [5:0] prev_cnt;

    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    hw_rst_n           = 1'b0;
    sw_rst             = 1'b0;
    aempty_value       = 5'd4;
    if_std.read_enable = 1'b0;
    if_stk.read_enable = 1'b0;
    if_fw.read_enable  = 1'b0;
    set_wptr(6'd0);
    tick(2);
    hw_rst_n = 1'b1;
    tick(1);

    check("rst_rdempty", rdempty_std, 1);
    check("rst_aempty", ae_std, 1);
    check("rst_underflow", uf_std, 0);
    check("rst_level", lvl_std, 0);
    check("rst_count", cnt_std, 0);
    check("rst_rptr_gray", rptr_gray_std, 0);
    check("rst_read_valid", if_std.read_valid, 0);
    check("rst_fwft_valid", if_fw.read_valid, 0);

    // single entry, standard mode
    mem[0] = 32'h11;
    set_wptr(6'd1);
    tick(2);
    check("single_still_empty", rdempty_std, 1);
    tick(1);
    check("single_not_empty", rdempty_std, 0);
    check("single_level", lvl_std, 1);
    check("single_aempty", ae_std, 1);
    check("single_fwft_valid", if_fw.read_valid, 1);
    check("single_fwft_data", if_fw.read_data, 32'h11);
    if_std.read_enable = 1'b1;
    #1;
    check("single_raddr", if_std.mem_raddr, 0);
    check("single_ren", if_std.mem_ren, 1);
    tick(1);
    if_std.read_enable = 1'b0;
    check("single_valid", if_std.read_valid, 1);
    check("single_data", if_std.read_data, 32'h11);
    check("single_empty_after", rdempty_std, 1);
    check("single_count", cnt_std, 1);
    check("single_rptr_gray", rptr_gray_std, 1);
    check("single_level_after", lvl_std, 0);
    tick(1);
    check("single_valid_drop", if_std.read_valid, 0);

    // full drain
    do_sw_rst();
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
    set_wptr(6'd32);
    tick(3);
    check("full_level", lvl_std, 32);
    check("full_aempty", ae_std, 0);
    check("full_rdempty", rdempty_std, 0);
    check("full_fwft_level", lvl_fw, 32);
    if_std.read_enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick(1);
      check("drain_valid", if_std.read_valid, 1);
      check("drain_data", if_std.read_data, 32'h100 + 32'(k));
      if (k == 26) begin
        check("drain_level5", lvl_std, 5);
        check("drain_aempty_lo", ae_std, 0);
      end
      if (k == 27) begin
        check("drain_level4", lvl_std, 4);
        check("drain_aempty_hi", ae_std, 1);
      end
      if (k == 30) check("drain_last_not_empty", rdempty_std, 0);
    end
    if_std.read_enable = 1'b0;
    check("drain_empty", rdempty_std, 1);
    check("drain_rptr_gray", rptr_gray_std, 32'h30);
    check("drain_level0", lvl_std, 0);
    check("drain_underflow", uf_std, 0);

    // underflow, pulse and sticky
    do_sw_rst();
    if_std.read_enable = 1'b1;
    if_stk.read_enable = 1'b1;
    #1;
    check("uf_no_ren", if_std.mem_ren, 0);
    tick(1);
    check("uf_std_c1", uf_std, 1);
    check("uf_stk_c1", uf_stk, 1);
    tick(1);
    if_std.read_enable = 1'b0;
    if_stk.read_enable = 1'b0;
    check("uf_std_c2", uf_std, 1);
    check("uf_stk_c2", uf_stk, 1);
    tick(1);
    check("uf_std_c3", uf_std, 0);
    check("uf_stk_c3", uf_stk, 1);
    check("uf_count", cnt_std, 0);
    check("uf_valid", if_std.read_valid, 0);
    tick(3);
    check("uf_stk_hold", uf_stk, 1);
    do_sw_rst();
    check("uf_stk_clear", uf_stk, 0);

    // pointer wrap over 70 entries
    do_sw_rst();
    n_rd = 0; wcnt = 0; cyc = 0; saw_wrap = 1'b0; prev_cnt = 6'd0;
    while (n_rd < 70 && cyc < 400) begin
      if (wcnt < 70) begin
        mem[wcnt % 32] = 32'(wcnt);
        wcnt++;
        set_wptr(6'(wcnt));
      end
      if_std.read_enable = !rdempty_std;
      tick(1);
      cyc++;
      if (if_std.read_valid) begin
        check("wrap_data", if_std.read_data, 32'(n_rd));
        n_rd++;
      end
      if (prev_cnt == 6'd63 && cnt_std == 6'd0) saw_wrap = 1'b1;
      prev_cnt = cnt_std;
    end
    if_std.read_enable = 1'b0;
    check("wrap_reads", 32'(n_rd), 70);
    check("wrap_seen", saw_wrap, 1);
    check("wrap_count", cnt_std, 6);
    check("wrap_rptr_gray", rptr_gray_std, 32'h5);
    check("wrap_empty", rdempty_std, 1);

    // soft reset mid-burst
    do_sw_rst();
    for (int i = 0; i < 8; i++) mem[i] = 32'h50 + 32'(i);
    set_wptr(6'd8);
    tick(3);
    if_std.read_enable = 1'b1;
    tick(1);
    check("burst_valid", if_std.read_valid, 1);
    check("burst_data", if_std.read_data, 32'h50);
    tick(1);
    sw_rst = 1'b1;
    set_wptr(6'd0);
    tick(1);
    sw_rst = 1'b0;
    if_std.read_enable = 1'b0;
    check("swrst_valid", if_std.read_valid, 0);
    check("swrst_count", cnt_std, 0);
    check("swrst_rdempty", rdempty_std, 1);
    check("swrst_level", lvl_std, 0);
    check("swrst_rptr_gray", rptr_gray_std, 0);
    check("swrst_aempty", ae_std, 1);

    // first-word-fall-through
    do_sw_rst();
    mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC;
    set_wptr(6'd3);
    tick(3);
    check("fwft_head_valid", if_fw.read_valid, 1);
    check("fwft_head_data", if_fw.read_data, 32'hA);
    if_fw.read_enable = 1'b1;
    tick(1);
    check("fwft_b_valid", if_fw.read_valid, 1);
    check("fwft_b_data", if_fw.read_data, 32'hB);
    tick(1);
    check("fwft_c_valid", if_fw.read_valid, 1);
    check("fwft_c_data", if_fw.read_data, 32'hC);
    tick(1);
    if_fw.read_enable = 1'b0;
    check("fwft_empty", rdempty_fw, 1);
    check("fwft_valid_drop", if_fw.read_valid, 0);
    check("fwft_count", cnt_fw, 3);
    check("fwft_underflow", uf_fw, 0);

    // asynchronous reset mid-cycle
    do_sw_rst();
    set_wptr(6'd5);
    tick(3);
    if_std.read_enable = 1'b1;
    tick(2);
    if_std.read_enable = 1'b0;
    tick(1);
    check("pre_hwrst_count", cnt_std, 2);
    check("pre_hwrst_level", lvl_std, 3);
    #3;
    hw_rst_n = 1'b0;
    #1;
    check("hwrst_rdempty", rdempty_std, 1);
    check("hwrst_aempty", ae_std, 1);
    check("hwrst_underflow", uf_std, 0);
    check("hwrst_level", lvl_std, 0);
    check("hwrst_count", cnt_std, 0);
    check("hwrst_rptr_gray", rptr_gray_std, 0);
    check("hwrst_fwft_valid", if_fw.read_valid, 0);
    set_wptr(6'd0);
    @(posedge rclk);
    #1;
    hw_rst_n = 1'b1;
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
Read-domain controller for the parametrised async FIFO. It owns the read pointer and synchronises the write pointer into rclk. It generates the rdempty, rd_almost_empty and underflow flags, the level and count outputs, and the read-side addressing of the dual-port RAM. It generalises the read side in data width and depth, makes the synchroniser depth configurable, and adds a first-word-fall-through mode and a sticky-underflow option.

Parameters:
DATA_W, 32, read data width
ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W
SYNC_STAGES, 2, flops in the write-pointer synchroniser (min 2)
FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through
STICKY_UNDERFLOW, 0, 0 = underflow is a 1-cycle pulse, 1 = underflow holds until reset or sw_rst

Ports:
rclk  in  1  read clock; the only clock
hw_rst_n  in  1  reset: asynchronous assert, active-low
sw_rst  in  1  synchronous soft flush, active-high
read_enable  in  1  read request
aempty_value  in  ADDR_W  almost-empty threshold
wptr_gray  in  ADDR_W+1  Gray write pointer from the write domain (asynchronous)
rptr_gray  out  ADDR_W+1  registered Gray read pointer, to the write domain
mem_raddr  out  ADDR_W  RAM read address
mem_ren  out  1  RAM read enable
mem_rdata  in  DATA_W  RAM registered read data
read_data  out  DATA_W  read data (= mem_rdata)
read_valid  out  1  read_data qualifier
rdempty  out  1  FIFO empty
rd_almost_empty  out  1  rd_level <= aempty_value
underflow  out  1  read attempted while empty
fifo_read_count  out  ADDR_W+1  accepted reads, modulo 2**(ADDR_W+1)
rd_level  out  ADDR_W+1  occupancy seen from the read domain, 0..DEPTH

Behaviour:
- Reset, asynchronous on hw_rst_n low:
  - rptr_bin and rptr_gray = 0; all synchroniser flops = 0.
  - rdempty = 1, rd_almost_empty = 1.
  - underflow, read_valid, rd_level and fifo_read_count = 0.
- sw_rst: sampled at the rclk edge; clears the same state to the same values. It has priority over read_enable. The system asserts sw_rst in both domains together.
- Write-pointer synchronisation: wptr_gray passes through SYNC_STAGES flops to give wq_gray, then Gray-to-binary to give wq_bin.
- Accept: accept = read_enable && !rdempty. On accept, rptr_bin_next = rptr_bin + 1, wrapping modulo 2**(ADDR_W+1). rptr_gray is registered bin2gray(rptr_bin_next).
- Flags and level: all registered from next-state values.
  - rdempty <= (bin2gray(rptr_bin_next) == wq_gray).
  - rd_level <= wq_bin - rptr_bin_next, computed at width ADDR_W+1 with wrap.
  - rd_almost_empty <= (rd_level_next <= aempty_value), an unsigned compare with aempty_value zero-extended.
- fifo_read_count always equals rptr_bin.
- Standard mode (FWFT=0):
  - mem_raddr = rptr_bin[ADDR_W-1:0]; mem_ren = accept.
  - read_valid is registered accept, so read_data is valid the cycle after accept.
- FWFT mode (FWFT=1):
  - mem_raddr = rptr_bin_next[ADDR_W-1:0]; mem_ren = 1.
  - read_valid = !rdempty, and read_data shows the head entry whenever read_valid = 1.
  - read_enable with read_valid = 1 consumes the head; the next entry appears the following cycle with no bubble.
- Underflow: the condition is read_enable && rdempty at the edge. Underflow asserts the next cycle. The pointer does not move and mem_ren is not raised in standard mode.
  - STICKY_UNDERFLOW=0: underflow is high for one cycle per offending cycle.
  - STICKY_UNDERFLOW=1: underflow stays high until hw_rst_n or sw_rst.
- Boundaries:
  - Full FIFO: rd_level = DEPTH; it never exceeds DEPTH when the write side is correct.
  - Read of the last entry: rdempty rises the cycle after the accept.
  - Write-to-empty: rdempty falls SYNC_STAGES+1 rclk cycles after the wptr_gray change.
  - Pointer wrap past 2**(ADDR_W+1)-1 to 0 is seamless.
  - Reset mid-burst: outputs return to reset values and any pending read_valid is dropped.

Decomposition:
- Package fifo_pkg holds:
  - the bin2gray and gray2bin functions, parameterised by width;
  - default constants FIFO_DATA_W=32, FIFO_ADDR_W=5, FIFO_SYNC_STAGES=2.
- Sub-module fifo_ptr_sync holds the SYNC_STAGES-deep Gray synchroniser, reset by hw_rst_n and cleared by sw_rst. The write-side controller reuses it.

Test Plan:
- Reset check: drive hw_rst_n low mid-cycle -> immediately rdempty=1, rd_almost_empty=1, underflow=0, rd_level=0, fifo_read_count=0, rptr_gray=0.
- Single-entry read, FWFT=0: write pointer 0->1 -> rdempty falls 3 cycles later and rd_level=1; read_enable for 1 cycle -> mem_raddr=0 with mem_ren=1, read_valid=1 the next cycle, rdempty=1, fifo_read_count=1.
- Full drain: wptr = 32 (Gray 0x30), aempty_value=4 -> rd_level=32 and rd_almost_empty=0; after 28 reads rd_level=4 and rd_almost_empty=1; after 32 reads rdempty=1, rptr_gray=0x30.
- Underflow: read_enable while empty, for 2 cycles -> STICKY_UNDERFLOW=0 gives 2 cycles of underflow and fifo_read_count unchanged; STICKY_UNDERFLOW=1 holds underflow until sw_rst.
- Wrap and soft reset: 70 writes/reads -> fifo_read_count wraps 63->0 and reads 6 at the end; sw_rst mid-burst -> next cycle shows reset values and read_valid=0.
- FWFT=1: write 3 entries 0xA,0xB,0xC -> read_data=0xA with read_valid=1 before any read_enable; 3 back-to-back reads -> 0xB then 0xC with no bubble, then rdempty=1 and read_valid=0.
